// File: rtl/pipeline_interlock_controller_pkg.sv
// Shared ISA constants, field positions and interlock FSM encoding.
// Also used by the RAW bypass controller.
package pipeline_interlock_controller_pkg;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RD_HI  = 26;
  localparam int RD_LO  = 22;
  localparam int RS_HI  = 21;
  localparam int RS_LO  = 17;
  localparam int RT_HI  = 16;
  localparam int RT_LO  = 12;
  localparam int ALU_HI = 6;
  localparam int ALU_LO = 2;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam logic [4:0] REG_STATUS = 5'd30;
  localparam logic [4:0] REG_RA     = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } md_state_e;

  function automatic logic [4:0] fld_rd(input logic [31:0] insn);
    return insn[RD_HI:RD_LO];
  endfunction

  function automatic logic [4:0] fld_rs(input logic [31:0] insn);
    return insn[RS_HI:RS_LO];
  endfunction

  function automatic logic [4:0] fld_rt(input logic [31:0] insn);
    return insn[RT_HI:RT_LO];
  endfunction

endpackage

// File: rtl/insn_reg_usage_decoder.sv
// Classifies which register fields an instruction reads/writes.
// Store data (sw rd) is deliberately not a read: it is forwarded MW->XM.
module insn_reg_usage_decoder
  import pipeline_interlock_controller_pkg::*;
(
  input  logic [31:0] i_insn,
  output logic        o_readsRS,
  output logic        o_readsRT,
  output logic        o_readsRD,
  output logic        o_writesRD,
  output logic        o_isLoad,
  output logic        o_isMulDiv,
  output logic        o_isMul
);

  logic [4:0] w_opc;
  logic [4:0] w_aluop;
  logic       w_isR;
  logic       w_unused;

  assign w_opc    = i_insn[OPC_HI:OPC_LO];
  assign w_aluop  = i_insn[ALU_HI:ALU_LO];
  assign w_isR    = (w_opc == OP_RTYPE);
  assign w_unused = ^{i_insn[RD_HI:ALU_HI+1], i_insn[ALU_LO-1:0]};

  always_comb begin
    o_readsRS  = !(w_opc inside {OP_J, OP_JAL, OP_SETX, OP_BEX});
    o_readsRT  = w_isR && !(w_aluop inside {ALU_SLL, ALU_SRA});
    o_readsRD  = w_opc inside {OP_BNE, OP_JR, OP_BLT};
    o_writesRD = w_isR || (w_opc == OP_ADDI) || (w_opc == OP_LW);
    o_isLoad   = (w_opc == OP_LW);
    o_isMulDiv = w_isR && (w_aluop inside {ALU_MUL, ALU_DIV});
    o_isMul    = w_isR && (w_aluop == ALU_MUL);
  end

endmodule

// File: rtl/pipeline_interlock_controller.sv
// Stall/flush interlock: load-use bubble, taken-branch squash and the
// multi-cycle mult/div handshake with timeout and a saturating stall counter.
module pipeline_interlock_controller
  import pipeline_interlock_controller_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      inFD,
  input  logic [31:0]      inDX,
  input  logic             branchTaken,
  input  logic             multdivRdy,
  input  logic             multdivExc,
  output logic             stallPC,
  output logic             stallFD,
  output logic             stallDX,
  output logic             nopToDX,
  output logic             nopToXM,
  output logic             flushFD,
  output logic             ctrlMult,
  output logic             ctrlDiv,
  output logic             mdResultValid,
  output logic             mdOvf,
  output logic             mdTimeout,
  output logic [CNT_W-1:0] stallCount
);

  localparam int TW = $clog2(MD_TIMEOUT + 1);

  logic w_fdReadsRS, w_fdReadsRT, w_fdReadsRD, w_fdWritesRD;
  logic w_fdIsLoad, w_fdIsMulDiv, w_fdIsMul;
  logic w_dxReadsRS, w_dxReadsRT, w_dxReadsRD, w_dxWritesRD;
  logic w_dxIsLoad, w_dxIsMulDiv, w_dxIsMul;
  logic w_unused;

  insn_reg_usage_decoder u_dec_fd (
    .i_insn(inFD), .o_readsRS(w_fdReadsRS), .o_readsRT(w_fdReadsRT),
    .o_readsRD(w_fdReadsRD), .o_writesRD(w_fdWritesRD), .o_isLoad(w_fdIsLoad),
    .o_isMulDiv(w_fdIsMulDiv), .o_isMul(w_fdIsMul)
  );

  insn_reg_usage_decoder u_dec_dx (
    .i_insn(inDX), .o_readsRS(w_dxReadsRS), .o_readsRT(w_dxReadsRT),
    .o_readsRD(w_dxReadsRD), .o_writesRD(w_dxWritesRD), .o_isLoad(w_dxIsLoad),
    .o_isMulDiv(w_dxIsMulDiv), .o_isMul(w_dxIsMul)
  );

  assign w_unused = ^{w_fdWritesRD, w_fdIsLoad, w_fdIsMulDiv, w_fdIsMul,
                      w_dxReadsRS, w_dxReadsRT, w_dxReadsRD, w_dxWritesRD};

  md_state_e        r_state;
  logic [TW-1:0]    r_timer;
  logic             r_mdStall, r_ctrlMult, r_ctrlDiv, r_mdValid, r_mdOvf, r_mdTimeout;
  logic [CNT_W-1:0] r_stallCount;

  logic [4:0] w_rdDX;
  logic       w_idle, w_hazard, w_flush, w_loadUse, w_timeoutHit;

  assign w_rdDX   = fld_rd(inDX);
  assign w_idle   = !reset && (r_state == ST_IDLE);
  assign w_hazard = (w_fdReadsRS && (fld_rs(inFD) == w_rdDX)) ||
                    (w_fdReadsRT && (fld_rt(inFD) == w_rdDX)) ||
                    (w_fdReadsRD && (fld_rd(inFD) == w_rdDX));
  assign w_flush     = w_idle && branchTaken;
  assign w_loadUse   = w_idle && !branchTaken && w_dxIsLoad &&
                       (w_rdDX != REG_ZERO) && w_hazard;
  assign w_timeoutHit = !reset && (r_state == ST_BUSY) && !multdivRdy &&
                        (r_timer == TW'(MD_TIMEOUT - 1));

  always_comb begin
    stallPC       = r_mdStall | w_loadUse;
    stallFD       = r_mdStall | w_loadUse;
    stallDX       = r_mdStall;
    nopToDX       = w_flush | w_loadUse | w_timeoutHit;
    nopToXM       = r_mdStall;
    flushFD       = w_flush;
    ctrlMult      = r_ctrlMult;
    ctrlDiv       = r_ctrlDiv;
    mdResultValid = r_mdValid;
    mdOvf         = r_mdOvf;
    mdTimeout     = r_mdTimeout;
    stallCount    = r_stallCount;
  end

  // Output flags are registered together with the state they belong to,
  // so each is loaded on the transition into that state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_mdStall   <= 1'b0;
      r_ctrlMult  <= 1'b0;
      r_ctrlDiv   <= 1'b0;
      r_mdValid   <= 1'b0;
      r_mdOvf     <= 1'b0;
      r_mdTimeout <= 1'b0;
    end else begin
      r_ctrlMult <= 1'b0;
      r_ctrlDiv  <= 1'b0;
      r_mdValid  <= 1'b0;
      r_mdOvf    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_dxIsMulDiv && !branchTaken) begin
            r_state    <= ST_ISSUE;
            r_mdStall  <= 1'b1;
            r_ctrlMult <= w_dxIsMul;
            r_ctrlDiv  <= !w_dxIsMul;
          end
        end
        ST_ISSUE, ST_BUSY: begin
          if (multdivRdy) begin
            r_state   <= ST_DONE;
            r_mdStall <= 1'b0;
            r_mdValid <= 1'b1;
            r_mdOvf   <= multdivExc;
          end else if (r_state == ST_ISSUE) begin
            r_state <= ST_BUSY;
            r_timer <= '0;
          end else if (r_timer == TW'(MD_TIMEOUT - 1)) begin
            r_state     <= ST_IDLE;
            r_mdStall   <= 1'b0;
            r_mdTimeout <= 1'b1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stallCount <= '0;
    end else if (stallPC && (r_stallCount != '1)) begin
      r_stallCount <= r_stallCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_interlock_controller.sv
// Directed bench for pipeline_interlock_controller with hand-computed control vectors.
module tb_pipeline_interlock_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] inFD, inDX;
  logic        branchTaken, multdivRdy, multdivExc;
  logic        stallPC, stallFD, stallDX, nopToDX, nopToXM, flushFD;
  logic        ctrlMult, ctrlDiv, mdResultValid, mdOvf, mdTimeout;
  logic [15:0] stallCount;

  int errors = 0;
  int checks = 0;

  pipeline_interlock_controller #(.MD_TIMEOUT(40), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .inFD(inFD), .inDX(inDX),
    .branchTaken(branchTaken), .multdivRdy(multdivRdy), .multdivExc(multdivExc),
    .stallPC(stallPC), .stallFD(stallFD), .stallDX(stallDX), .nopToDX(nopToDX),
    .nopToXM(nopToXM), .flushFD(flushFD), .ctrlMult(ctrlMult), .ctrlDiv(ctrlDiv),
    .mdResultValid(mdResultValid), .mdOvf(mdOvf), .mdTimeout(mdTimeout),
    .stallCount(stallCount)
  );

  always #5 clock = ~clock;

  // {stallPC,stallFD,stallDX,nopToDX,nopToXM,flushFD,ctrlMult,ctrlDiv,valid,ovf,timeout}
  logic [10:0] outs;
  assign outs = {stallPC, stallFD, stallDX, nopToDX, nopToXM, flushFD,
                 ctrlMult, ctrlDiv, mdResultValid, mdOvf, mdTimeout};

  localparam logic [10:0] E_NONE = 11'b00000000000;
  localparam logic [10:0] E_LU   = 11'b11010000000;
  localparam logic [10:0] E_BR   = 11'b00010100000;
  localparam logic [10:0] E_ISM  = 11'b11101010000;
  localparam logic [10:0] E_ISD  = 11'b11101001000;
  localparam logic [10:0] E_BSY  = 11'b11101000000;
  localparam logic [10:0] E_DONE = 11'b00000000100;
  localparam logic [10:0] E_DOVF = 11'b00000000110;
  localparam logic [10:0] E_TO   = 11'b11111000000;
  localparam logic [10:0] E_STK  = 11'b00000000001;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered at posedge+1; checks mid-cycle then advances one clock.
  task automatic cyc(input string tag, input logic [10:0] exp);
    @(negedge clock);
    chk(tag, 32'(outs), 32'(exp));
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] alu, rd, rs, rt);
    return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] op, rd, rs);
    return {op, rd, rs, 17'd0};
  endfunction

  logic [31:0] NOP, LW3, LW0, ADD_U3, ADD_U0, SW_D3, SW_B3, BNE3, SLL3, MUL, DIV;

  initial begin
    NOP    = 32'd0;
    LW3    = itype(5'b01000, 5'd3, 5'd1);
    LW0    = itype(5'b01000, 5'd0, 5'd1);
    ADD_U3 = rtype(5'b00000, 5'd4, 5'd3, 5'd5);
    ADD_U0 = rtype(5'b00000, 5'd4, 5'd0, 5'd5);
    SW_D3  = itype(5'b00111, 5'd3, 5'd7);
    SW_B3  = itype(5'b00111, 5'd7, 5'd3);
    BNE3   = itype(5'b00010, 5'd3, 5'd1);
    SLL3   = rtype(5'b00100, 5'd4, 5'd1, 5'd3);
    MUL    = rtype(5'b00110, 5'd4, 5'd1, 5'd2);
    DIV    = rtype(5'b00111, 5'd4, 5'd1, 5'd2);

    // Reset with hazards present on every input: everything must stay low.
    reset = 1'b1; inDX = LW3; inFD = ADD_U3;
    branchTaken = 1'b1; multdivRdy = 1'b1; multdivExc = 1'b1;
    #3;
    chk("reset_outs", 32'(outs), 32'(E_NONE));
    chk("reset_cnt", 32'(stallCount), 32'd0);
    branchTaken = 1'b0; multdivRdy = 1'b0; multdivExc = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;

    // Load-use: one bubble, then advance.
    cyc("lu_add", E_LU);
    inDX = ADD_U3; inFD = NOP;
    cyc("lu_advance", E_NONE);
    chk("lu_cnt", 32'(stallCount), 32'd1);

    inDX = LW0; inFD = ADD_U0;  cyc("lu_r0", E_NONE);
    inDX = LW3; inFD = SW_D3;   cyc("lu_sw_data", E_NONE);
    inFD = SW_B3;               cyc("lu_sw_base", E_LU);
    inFD = BNE3;                cyc("lu_bne_rd", E_LU);
    inFD = SLL3;                cyc("lu_sll_rt", E_NONE);
    chk("lu_cnt3", 32'(stallCount), 32'd3);

    // Taken branch over a load-use pair: squash, no stall.
    inFD = ADD_U3; branchTaken = 1'b1;
    cyc("br_flush", E_BR);
    branchTaken = 1'b0;
    chk("br_cnt", 32'(stallCount), 32'd3);

    // mul with ready 17 cycles after the start pulse.
    inDX = MUL; inFD = NOP;
    cyc("mul_idle", E_NONE);
    cyc("mul_issue", E_ISM);
    for (int k = 1; k <= 16; k++) cyc("mul_busy", E_BSY);
    multdivRdy = 1'b1;
    cyc("mul_rdy", E_BSY);
    multdivRdy = 1'b0;
    cyc("mul_done", E_DONE);
    chk("mul_cnt", 32'(stallCount), 32'd21);

    // Back-to-back div, ready in ISSUE with exception.
    inDX = DIV;
    cyc("div_idle", E_NONE);
    multdivRdy = 1'b1; multdivExc = 1'b1;
    cyc("div_issue", E_ISD);
    multdivRdy = 1'b0; multdivExc = 1'b0;
    cyc("div_done", E_DOVF);
    chk("div_cnt", 32'(stallCount), 32'd22);

    // mul that never completes: abandoned after 40 BUSY cycles.
    inDX = MUL;
    cyc("to_idle", E_NONE);
    cyc("to_issue", E_ISM);
    for (int k = 1; k <= 39; k++) cyc("to_busy", E_BSY);
    cyc("to_expire", E_TO);
    inDX = NOP;
    cyc("to_sticky", E_STK);
    cyc("to_sticky2", E_STK);
    chk("to_cnt", 32'(stallCount), 32'd63);

    // Reset in the middle of BUSY.
    inDX = MUL;
    cyc("rb_idle", E_STK);
    cyc("rb_issue", E_ISM | E_STK);
    for (int k = 0; k < 3; k++) cyc("rb_busy", E_BSY | E_STK);
    #2 reset = 1'b1;
    #1;
    chk("rb_outs", 32'(outs), 32'(E_NONE));
    chk("rb_cnt", 32'(stallCount), 32'd0);
    inDX = NOP;
    @(posedge clock); #1;
    reset = 1'b0;
    cyc("rb_after", E_NONE);

    // Counter saturation under a held load-use stall.
    inDX = LW3; inFD = ADD_U3;
    repeat (65534) @(posedge clock);
    #1;
    chk("sat_pre", 32'(stallCount), 32'd65534);
    repeat (70000 - 65534) @(posedge clock);
    #1;
    chk("sat_hold", 32'(stallCount), 32'd65535);
    chk("sat_outs", 32'(outs), 32'(E_LU));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
